// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive-side blocks:
//   - rx_cause_e     : RxIrqCause codes reported to the DSP status block
//   - rx_irq_state_e : state encoding of the RX interrupt scheduler
//   - TRIG_SEL_*     : TrigSel codes (FIFO depth that raises the level cause)
//   - RX_TO_BITS_DEFAULT : default character-timeout length in bit times
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'b00,
        CAUSE_LEVEL = 2'b01,
        CAUSE_TOUT  = 2'b10,
        CAUSE_OVR   = 2'b11
    } rx_cause_e;

    typedef enum logic [1:0] {
        RXI_IDLE = 2'd0,
        RXI_WAIT = 2'd1,
        RXI_TRIG = 2'd2,
        RXI_TOUT = 2'd3
    } rx_irq_state_e;

    // TrigSel codes; 5, 6 and 7 all select the 14-entry level.
    localparam logic [2:0] TRIG_SEL_1  = 3'd0;
    localparam logic [2:0] TRIG_SEL_2  = 3'd1;
    localparam logic [2:0] TRIG_SEL_4  = 3'd2;
    localparam logic [2:0] TRIG_SEL_8  = 3'd3;
    localparam logic [2:0] TRIG_SEL_12 = 3'd4;
    localparam logic [2:0] TRIG_SEL_14 = 3'd5;

    // Four 10-bit characters of line idle time.
    localparam int RX_TO_BITS_DEFAULT = 40;

endpackage

// File: rtl/uart_rx_timeout_cnt.sv
// -----------------------------------------------------------------------------
// uart_rx_timeout_cnt
// Counts idle bit times while received data sits below the trigger level.
// Ports:
//   clk, srst : clock and synchronous active-high reset
//   clr       : restart the count (wins over tick in the same cycle)
//   tick      : one-cycle pulse per bit time
//   en        : timeout allowed to fire; when low the count parks at TO_BITS-1
//   expire    : combinational pulse on the tick that completes TO_BITS ticks
// -----------------------------------------------------------------------------
module uart_rx_timeout_cnt #(
    parameter int CNT_W   = 6,
    parameter int TO_BITS = 40
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    input  logic tick,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_BITS - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             at_last;

    assign at_last = (cnt_reg == CNT_LAST);

    // The tick that lands on count TO_BITS-1 is tick number TO_BITS.
    assign expire = tick & en & ~clr & at_last;

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else if (clr || expire) begin
            cnt_reg <= '0;
        end else if (tick && !at_last) begin
            // Parking at the last value lets a late enable fire on the next tick.
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_irq_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_irq_ctrl
// Receive-side interrupt scheduler for the UART RX FIFO. Raises one DSP
// interrupt for overrun, trigger level reached, or character timeout.
// Ports:
//   DSP_CLK, RESET      : clock, synchronous active-high reset
//   FIFOEn              : FIFO mode (0: trigger on not-empty, no timeout)
//   RxIrqEn             : master interrupt enable
//   TimeoutEn           : timeout cause enable
//   TrigSel[2:0]        : trigger depth 1/2/4/8/12/14
//   BitTick             : bit-time pulse
//   RxWrStb, RxRdStb    : FIFO push / pop pulses
//   RxFIFO_*            : FIFO level flags
//   OverrunError        : overrun status level
//   OvrAck              : clears the sticky overrun flag
//   RX_IRQ              : registered interrupt request
//   RxIrqCause[1:0]     : registered cause (valid even when masked)
//   RxTimeout           : registered, high while in the timeout state
// -----------------------------------------------------------------------------
module uart_rx_irq_ctrl
    import uart_pkg::*;
#(
    parameter int TO_BITS = RX_TO_BITS_DEFAULT,
    parameter int CNT_W   = 6
) (
    input  logic       DSP_CLK,
    input  logic       RESET,
    input  logic       FIFOEn,
    input  logic       RxIrqEn,
    input  logic       TimeoutEn,
    input  logic [2:0] TrigSel,
    input  logic       BitTick,
    input  logic       RxWrStb,
    input  logic       RxRdStb,
    input  logic       RxFIFO_Empty,
    input  logic       RxFIFO_L2_Full,
    input  logic       RxFIFO_L4_Full,
    input  logic       RxFIFO_L8_Full,
    input  logic       RxFIFO_L12_Full,
    input  logic       RxFIFO_L14_Full,
    input  logic       OverrunError,
    input  logic       OvrAck,
    output logic       RX_IRQ,
    output logic [1:0] RxIrqCause,
    output logic       RxTimeout
);

    rx_irq_state_e state_reg;
    logic          ovr_reg;
    logic          ovr_prev_reg;
    logic          level_hit;
    logic          ovr_rise;
    logic          any_stb;
    logic          to_clr;
    logic          to_en;
    logic          to_expire;

    // Trigger level selection; outside FIFO mode any data is enough.
    always_comb begin
        level_hit = 1'b0;
        if (!FIFOEn) begin
            level_hit = ~RxFIFO_Empty;
        end else begin
            case (TrigSel)
                TRIG_SEL_1:  level_hit = ~RxFIFO_Empty;
                TRIG_SEL_2:  level_hit = RxFIFO_L2_Full;
                TRIG_SEL_4:  level_hit = RxFIFO_L4_Full;
                TRIG_SEL_8:  level_hit = RxFIFO_L8_Full;
                TRIG_SEL_12: level_hit = RxFIFO_L12_Full;
                default:     level_hit = RxFIFO_L14_Full;
            endcase
        end
    end

    assign any_stb  = RxWrStb | RxRdStb;
    assign ovr_rise = OverrunError & ~ovr_prev_reg;

    // Idle time only accumulates while data waits below the trigger level.
    assign to_clr = any_stb | RxFIFO_Empty | (state_reg != RXI_WAIT);
    assign to_en  = TimeoutEn & FIFOEn;

    uart_rx_timeout_cnt #(
        .CNT_W   (CNT_W),
        .TO_BITS (TO_BITS)
    ) u_timeout_cnt (
        .clk    (DSP_CLK),
        .srst   (RESET),
        .clr    (to_clr),
        .tick   (BitTick),
        .en     (to_en),
        .expire (to_expire)
    );

    always_ff @(posedge DSP_CLK) begin
        // Tracked through reset so a level already high is not seen as a new edge.
        ovr_prev_reg <= OverrunError;

        if (RESET) begin
            state_reg  <= RXI_IDLE;
            ovr_reg    <= 1'b0;
            RX_IRQ     <= 1'b0;
            RxIrqCause <= CAUSE_NONE;
            RxTimeout  <= 1'b0;
        end else begin
            // Outputs reflect the state held before this edge.
            RX_IRQ    <= RxIrqEn & (ovr_reg | (state_reg == RXI_TRIG) | (state_reg == RXI_TOUT));
            RxTimeout <= (state_reg == RXI_TOUT);
            if (ovr_reg)
                RxIrqCause <= CAUSE_OVR;
            else if (state_reg == RXI_TRIG)
                RxIrqCause <= CAUSE_LEVEL;
            else if (state_reg == RXI_TOUT)
                RxIrqCause <= CAUSE_TOUT;
            else
                RxIrqCause <= CAUSE_NONE;

            // Priority within each state: Empty > level > strobe > timeout.
            case (state_reg)
                RXI_IDLE: begin
                    if (!RxFIFO_Empty && level_hit)
                        state_reg <= RXI_TRIG;
                    else if (!RxFIFO_Empty)
                        state_reg <= RXI_WAIT;
                end
                RXI_WAIT: begin
                    if (RxFIFO_Empty)
                        state_reg <= RXI_IDLE;
                    else if (level_hit)
                        state_reg <= RXI_TRIG;
                    else if (to_expire)
                        state_reg <= RXI_TOUT;
                end
                RXI_TRIG: begin
                    if (RxFIFO_Empty)
                        state_reg <= RXI_IDLE;
                    else if (!level_hit)
                        state_reg <= RXI_WAIT;
                end
                RXI_TOUT: begin
                    if (RxFIFO_Empty)
                        state_reg <= RXI_IDLE;
                    else if (level_hit)
                        state_reg <= RXI_TRIG;
                    else if (any_stb)
                        state_reg <= RXI_WAIT;
                end
                default: state_reg <= RXI_IDLE;
            endcase

            // A new overrun edge outranks an acknowledge in the same cycle.
            if (ovr_rise)
                ovr_reg <= 1'b1;
            else if (OvrAck)
                ovr_reg <= 1'b0;
        end
    end

endmodule
